i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Downstream stage of the audio FIR. Consumes its mono sample stream (data/valid strobe) and serializes it as a standard Philips I2S stereo frame to the DAC, with the same sample in both slots.
- Generates BCLK/LRCLK from the system clock.
- Shift then saturate to DAC width.
- Small FIFO absorbs jitter between the upstream valid strobe and the frame boundary.
- Provides a per-frame strobe so upstream can pace its data_in_valid.

Parameters:
DATA_WIDTH, 32, input sample width (signed)
OUT_WIDTH, 24, DAC sample width; legal range 1..32
SHIFT, 0, arithmetic right shift applied before saturation; legal range 0..DATA_WIDTH-1
BCLK_HALF, 2, clk cycles per BCLK half-period; must be >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
data_in  in  DATA_WIDTH  signed sample from FIR
data_in_valid  in  1  one-cycle strobe; data_in is valid this cycle
status_clear  in  1  clears sticky flags
bclk  out  1  I2S bit clock
lrclk  out  1  word select; 0 = left, 1 = right
sdata  out  1  serial data, MSB first
frame_strobe  out  1  one-cycle pulse when a new frame is loaded
underrun  out  1  sticky; frame started with FIFO empty
overflow  out  1  sticky; sample dropped because FIFO was full
clip  out  1  sticky; saturation occurred

Behaviour:
- Reset: all outputs are 0, FIFO is empty, last-sample register is 0, divider count is 0, bit counter b is 63.
- Divider and BCLK:
  - Divider counts 0..BCLK_HALF-1; bclk toggles on wrap.
  - "Fall event" is the wrap cycle while bclk = 1.
  - bclk, lrclk and sdata all change only on fall events.
- Frame counter:
  - Each fall event sets b to (b+1) mod 64.
  - Frame = 64 BCLK, 32-bit slots.
  - lrclk = 1 for b in 31..62; lrclk = 0 for b = 63 and b in 0..30. LRCLK therefore leads the MSB by one BCLK.
- Frame load (fall event entering b = 0):
  - Pop FIFO into the last-sample register S. If the FIFO is empty, keep S and set underrun.
  - Load a 64-bit shift register with {S, 32-OUT_WIDTH zeros, S, 32-OUT_WIDTH zeros}.
  - Drive sdata = bit 63 of the shift register.
  - Pulse frame_strobe for exactly this clk cycle.
- Other fall events: shift left by 1, then drive sdata = new MSB.
- Conditioning on write: s = data_in >>> SHIFT.
  - If s > 2^(OUT_WIDTH-1)-1, store the max positive value and set clip.
  - If s < -2^(OUT_WIDTH-1), store the min negative value and set clip.
  - Otherwise store s[OUT_WIDTH-1:0].
  - Purely combinational ahead of the FIFO write.
- FIFO: depth 2.
  - A write on data_in_valid when full drops the new sample and sets overflow.
  - Same-cycle pop and write: the pop uses pre-write contents, then the write is accepted. A full FIFO therefore does not overflow.
  - An empty FIFO flags underrun even if a write arrives in the same cycle; that written sample is stored.
- Latency: a sample written into an empty FIFO is MSB-visible on sdata at the next frame load.
- Sticky flags:
  - Cleared by rst or status_clear.
  - If a set event and status_clear occur in the same cycle, set wins.
- Reset mid-frame: everything returns to reset state immediately. No partial frame is resumed. The first fall event after reset is a frame load.

Decomposition:
- Package i2s_pkg:
  - constants SLOT_BITS = 32 and FRAME_BITS = 64
  - function sat_shift(value, shift, out_width) returning the saturated value plus a clip bit
- Sub-module audio_sample_fifo: 2-entry FIFO with push/pop, full/empty and the same-cycle rule above.
- Divider, bit counter and shifter stay in i2s_tx.

Test Plan:
1. Reset with BCLK_HALF = 2 -> all outputs 0; first frame_strobe exactly 4 clk after rst deasserts; frame_strobe then repeats every 256 clk; lrclk is low for 32 BCLK then high for 32.
2. Write 0x0012_3456 (SHIFT = 0, OUT_WIDTH = 24) before a frame load -> both slots carry 0x123456 MSB first followed by 8 zeros; MSB sits one BCLK after the lrclk edge; clip stays 0.
3. Write 0x7FFF_FFFF, then 0x8000_0000 in the next frame -> slots carry 0x7FFFFF, then 0x800000; clip = 1. Pulse status_clear -> clip = 0.
4. One write, then none for 3 frames -> the sample repeats in every frame; underrun = 1 from the second frame load on.
5. Three writes within one frame (values 1, 2, 3) -> overflow = 1; the next frames output 1 then 2; 3 is never output.
6. Assert rst for 1 clk at b = 40 -> outputs go to 0 and b to 63 next cycle; FIFO is empty; the next frame outputs 0 and sets underrun.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - frame constants and sample conditioning shared by the I2S transmitter
package i2s_pkg;

   localparam int SLOT_BITS  = 32;
   localparam int FRAME_BITS = 64;

   typedef struct packed {
      logic [SLOT_BITS-1:0] value;
      logic                 clip;
   } sat_result_t;

   // Arithmetic shift then clamp to a signed out_width range; low out_width bits of value are the sample.
   function automatic sat_result_t sat_shift(input logic signed [63:0] value,
                                             input int                 shift,
                                             input int                 out_width);
      logic signed [63:0] s;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      sat_result_t        r;
      s     = value >>> shift;
      max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (out_width - 1));
      if (s > max_v) begin
         r.value = max_v[SLOT_BITS-1:0];
         r.clip  = 1'b1;
      end else if (s < min_v) begin
         r.value = min_v[SLOT_BITS-1:0];
         r.clip  = 1'b1;
      end else begin
         r.value = s[SLOT_BITS-1:0];
         r.clip  = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - two-entry sample FIFO; a same-cycle pop sees pre-write contents
module audio_sample_fifo
   import i2s_pkg::*;
#(
   parameter int WIDTH = SLOT_BITS
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [1:0]       count_q, count_d;
   logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
   logic             pop_ok, push_ok;
   logic [1:0]       wr_pos;

   always_comb begin
      pop_ok  = pop_i && (count_q != 2'd0);
      // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
      push_ok = push_i && ((count_q != 2'd2) || pop_ok);
      wr_pos  = count_q - {1'b0, pop_ok};
      e0_d    = e0_q;
      e1_d    = e1_q;
      if (pop_ok) begin
         e0_d = e1_q;
      end
      if (push_ok) begin
         if (wr_pos == 2'd0) begin
            e0_d = wdata_i;
         end else begin
            e1_d = wdata_i;
         end
      end
      count_d = count_q - {1'b0, pop_ok} + {1'b0, push_ok};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= 2'd0;
         e0_q    <= '0;
         e1_q    <= '0;
      end else begin
         count_q <= count_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
      end
   end

   assign rdata_o = e0_q;
   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - mono-to-stereo Philips I2S serializer with BCLK/LRCLK generation and sticky status
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 24,
   parameter int SHIFT      = 0,
   parameter int BCLK_HALF  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   input  logic                  status_clear,
   output logic                  bclk,
   output logic                  lrclk,
   output logic                  sdata,
   output logic                  frame_strobe,
   output logic                  underrun,
   output logic                  overflow,
   output logic                  clip
);

   localparam int CW = $clog2(BCLK_HALF);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  bclk_q, bclk_d;
   logic [5:0]            b_q, b_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [SLOT_BITS-1:0]  last_q, last_d;
   logic                  lrclk_q, lrclk_d, sdata_q, sdata_d, strobe_q, strobe_d;
   logic                  underrun_q, underrun_d, overflow_q, overflow_d, clip_q, clip_d;

   logic                  wrap, fall, load;
   logic signed [63:0]    din_ext;
   sat_result_t           cond;
   logic [SLOT_BITS-1:0]  slot_in, fifo_rdata;
   logic                  fifo_full, fifo_empty;

   assign din_ext = 64'(signed'(data_in));
   assign cond    = sat_shift(din_ext, SHIFT, OUT_WIDTH);
   // Samples are stored already left-justified in their 32-bit slot.
   assign slot_in = cond.value << (SLOT_BITS - OUT_WIDTH);

   assign wrap = (cnt_q == CW'(BCLK_HALF - 1));
   assign fall = wrap && bclk_q;
   assign load = fall && (b_q == 6'd63);

   audio_sample_fifo #(.WIDTH(SLOT_BITS)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (data_in_valid),
      .wdata_i (slot_in),
      .pop_i   (load),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      cnt_d    = wrap ? '0 : cnt_q + CW'(1);
      bclk_d   = bclk_q ^ wrap;
      b_d      = b_q;
      lrclk_d  = lrclk_q;
      sdata_d  = sdata_q;
      shreg_d  = shreg_q;
      last_d   = last_q;
      strobe_d = 1'b0;
      if (fall) begin
         b_d     = b_q + 6'd1;
         lrclk_d = (b_d >= 6'd31) && (b_d <= 6'd62);
         if (load) begin
            if (!fifo_empty) begin
               last_d = fifo_rdata;
            end
            shreg_d  = {last_d, last_d};
            strobe_d = 1'b1;
         end else begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
         end
         sdata_d = shreg_d[FRAME_BITS-1];
      end
      // Set events take priority over a simultaneous clear.
      underrun_d = (load && fifo_empty) || (underrun_q && !status_clear);
      overflow_d = (data_in_valid && fifo_full && !load) || (overflow_q && !status_clear);
      clip_d     = (data_in_valid && cond.clip) || (clip_q && !status_clear);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         bclk_q     <= 1'b0;
         b_q        <= 6'd63;
         shreg_q    <= '0;
         last_q     <= '0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         strobe_q   <= 1'b0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
         clip_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         bclk_q     <= bclk_d;
         b_q        <= b_d;
         shreg_q    <= shreg_d;
         last_q     <= last_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         strobe_q   <= strobe_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
         clip_q     <= clip_d;
      end
   end

   assign bclk         = bclk_q;
   assign lrclk        = lrclk_q;
   assign sdata        = sdata_q;
   assign frame_strobe = strobe_q;
   assign underrun     = underrun_q;
   assign overflow     = overflow_q;
   assign clip         = clip_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - randomized bench for i2s_tx checked cycle by cycle against a frame-level model
module tb_i2s_tx;

   localparam int DW        = 32;
   localparam int OW        = 24;
   localparam int SH        = 0;
   localparam int BH        = 2;
   localparam int FRAME_CLK = 64 * 2 * BH;
   localparam int LOAD_PH   = 2 * BH;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] data_in;
   logic          data_in_valid;
   logic          status_clear;
   logic          bclk, lrclk, sdata, frame_strobe, underrun, overflow, clip;

   always #5 clk = ~clk;

   i2s_tx #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .SHIFT(SH), .BCLK_HALF(BH)) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .status_clear  (status_clear),
      .bclk          (bclk),
      .lrclk         (lrclk),
      .sdata         (sdata),
      .frame_strobe  (frame_strobe),
      .underrun      (underrun),
      .overflow      (overflow),
      .clip          (clip)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: n counts clk edges since reset released; every frame is FRAME_CLK edges and loads at LOAD_PH.
   int            n       = 0;
   bit            started = 1'b0;
   logic [OW-1:0] fifo_m[$];
   logic [OW-1:0] s_m;
   logic [63:0]   word_m;
   bit            und_m, ovf_m, clip_m;

   function automatic void condition(input logic [DW-1:0] d, output logic [OW-1:0] v, output bit c);
      longint s, hi, lo;
      s  = longint'($signed(d)) >>> SH;
      hi = (longint'(1) << (OW - 1)) - 1;
      lo = -(longint'(1) << (OW - 1));
      c  = 1'b0;
      if (s > hi) begin
         v = hi[OW-1:0];
         c = 1'b1;
      end else if (s < lo) begin
         v = lo[OW-1:0];
         c = 1'b1;
      end else begin
         v = s[OW-1:0];
      end
   endfunction

   task automatic model_step();
      logic [OW-1:0] v;
      bit            c, su, so, sc;
      su = 1'b0; so = 1'b0; sc = 1'b0;
      if (rst) begin
         n = 0;
         fifo_m.delete();
         s_m    = '0;
         word_m = '0;
         und_m  = 1'b0;
         ovf_m  = 1'b0;
         clip_m = 1'b0;
      end else begin
         n++;
         if (n % FRAME_CLK == LOAD_PH) begin
            if (fifo_m.size() > 0) s_m = fifo_m.pop_front();
            else su = 1'b1;
            word_m = {s_m, {(32 - OW){1'b0}}, s_m, {(32 - OW){1'b0}}};
         end
         if (data_in_valid) begin
            condition(data_in, v, c);
            sc = c;
            if (fifo_m.size() < 2) fifo_m.push_back(v);
            else so = 1'b1;
         end
         und_m  = su | (und_m  & ~status_clear);
         ovf_m  = so | (ovf_m  & ~status_clear);
         clip_m = sc | (clip_m & ~status_clear);
      end
      started = 1'b1;
   endtask

   function automatic int cur_b();
      return (63 + n / (2 * BH)) % 64;
   endfunction

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (started) begin
         int b;
         b = cur_b();
         check_eq("bclk", bclk, 64'((n / BH) % 2));
         check_eq("lrclk", lrclk, 64'(b >= 31 && b <= 62));
         check_eq("sdata", sdata, word_m[63 - b]);
         check_eq("frame_strobe", frame_strobe, 64'(n % FRAME_CLK == LOAD_PH));
         check_eq("underrun", underrun, und_m);
         check_eq("overflow", overflow, ovf_m);
         check_eq("clip", clip, clip_m);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [DW-1:0] v);
      data_in       = v;
      data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      status_clear = 1'b1;
      step();
      status_clear = 1'b0;
   endtask

   task automatic wait_phase(input int ph);
      int k = 0;
      while ((n % FRAME_CLK) != ph && k < 2 * FRAME_CLK) begin
         step();
         k++;
      end
      if (k >= 2 * FRAME_CLK) check_eq("wait_phase_timeout", 64'(n % FRAME_CLK), 64'(ph));
   endtask

   task automatic wait_b(input int target);
      int k = 0;
      while (cur_b() != target && k < 2 * FRAME_CLK) begin
         step();
         k++;
      end
      if (k >= 2 * FRAME_CLK) check_eq("wait_b_timeout", 64'(cur_b()), 64'(target));
   endtask

   function automatic logic [DW-1:0] rand_sample();
      logic [DW-1:0] v;
      logic [DW-1:0] edges[4];
      edges[0] = 32'h007F_FFFF;
      edges[1] = 32'h0080_0000;
      edges[2] = 32'hFF80_0000;
      edges[3] = 32'hFF7F_FFFF;
      v = $urandom;
      case ($urandom_range(0, 2))
         0: v[31:23] = {9{v[23]}};
         1: v = edges[$urandom_range(0, 3)];
         default: ;
      endcase
      return v;
   endfunction

   initial begin
      rst           = 1'b1;
      data_in       = '0;
      data_in_valid = 1'b0;
      status_clear  = 1'b0;
      repeat (3) step();
      rst = 1'b0;

      put(32'h0012_3456);
      wait_phase(100);
      put(32'h7FFF_FFFF);
      wait_phase(100);
      put(32'h8000_0000);
      wait_phase(150);
      pulse_clear();

      wait_phase(200);
      put(rand_sample());
      repeat (4 * FRAME_CLK) step();

      wait_phase(10);
      put(32'd1);
      wait_phase(20);
      put(32'd2);
      wait_phase(30);
      put(32'd3);
      repeat (3 * FRAME_CLK) step();
      pulse_clear();

      // Writes landing exactly on the load edge: one with the FIFO full, one with it empty.
      wait_phase(50);
      put(rand_sample());
      put(rand_sample());
      wait_phase(LOAD_PH - 1);
      put(rand_sample());
      repeat (3 * FRAME_CLK) step();
      wait_phase(LOAD_PH - 1);
      put(rand_sample());
      repeat (FRAME_CLK) step();

      for (int i = 0; i < 6 * FRAME_CLK; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            data_in       = rand_sample();
            data_in_valid = 1'b1;
         end
         status_clear = ($urandom_range(0, 299) == 0);
         step();
         data_in_valid = 1'b0;
         status_clear  = 1'b0;
      end

      wait_phase(60);
      put(rand_sample());
      wait_b(40);
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (2 * FRAME_CLK) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
